// File: rtl/vote_round_collector_pkg.sv
// Shared types and helpers for the three-judge vote round collector.
package vote_pkg;

  localparam int JUDGE_N = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  function automatic logic maj3(input logic [2:0] votes);
    return (votes[0] & votes[1]) | (votes[0] & votes[2]) | (votes[1] & votes[2]);
  endfunction

  function automatic logic [1:0] popcnt3(input logic [2:0] votes);
    return {1'b0, votes[0]} + {1'b0, votes[1]} + {1'b0, votes[2]};
  endfunction

endpackage

// File: rtl/vote_round_collector_if.sv
// Round-control and result bundle between judge front ends and the collector.
interface vote_round_collector_if;
  import vote_pkg::*;

  logic               start;
  logic [JUDGE_N-1:0] vote_valid;
  logic [JUDGE_N-1:0] vote_val;
  logic               busy;
  logic [JUDGE_N-1:0] voted;
  logic [1:0]         yes_cnt;
  logic               result;
  logic               timed_out;
  logic               done;

  modport master (
    output start, vote_valid, vote_val,
    input  busy, voted, yes_cnt, result, timed_out, done
  );

  modport slave (
    input  start, vote_valid, vote_val,
    output busy, voted, yes_cnt, result, timed_out, done
  );

endinterface

// File: rtl/vote_round_collector_timer.sv
// Round window timer: saturates at TIMEOUT_CYCLES-1 and flags that terminal count.
module round_timer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o = (cnt_q == TC_VAL);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vote_round_collector.sv
// Vote round collector: latches first votes within a window, publishes 2-of-3 result.
// Optional build macro VOTE_EARLY_DECIDE_EN closes a round once two latched votes agree.
module vote_round_collector
  import vote_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  vote_round_collector_if.slave vrc
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  state_e             state_q, state_d;
  logic [JUDGE_N-1:0] voted_q, voted_d;
  logic [JUDGE_N-1:0] vals_q, vals_d;
  logic [1:0]         yes_cnt_q, yes_cnt_d;
  logic               result_q, result_d;
  logic               timed_out_q, timed_out_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [JUDGE_N-1:0] take_s;
  logic [JUDGE_N-1:0] voted_new_s;
  logic [JUDGE_N-1:0] vals_new_s;
  logic               early_s;
  logic               tc_s;
  logic               timer_clr_s;
  logic               timer_en_s;
  logic               close_s;

  // Only a judge's first strobe of the round is latched.
  assign take_s      = vrc.vote_valid & ~voted_q;
  assign voted_new_s = voted_q | take_s;
  assign vals_new_s  = (vals_q & ~take_s) | (vrc.vote_val & take_s);

`ifdef VOTE_EARLY_DECIDE_EN
  logic [1:0] yes_new_s;
  logic [1:0] n_new_s;
  assign yes_new_s = popcnt3(vals_new_s);
  assign n_new_s   = popcnt3(voted_new_s);
  assign early_s   = (yes_new_s >= 2'd2) || ((n_new_s - yes_new_s) >= 2'd2);
`else
  assign early_s   = 1'b0;
`endif

  assign timer_clr_s = (state_q == IDLE) && vrc.start;
  assign timer_en_s  = (state_q == COLLECT);
  assign close_s     = (state_q == COLLECT) && ((&voted_new_s) || tc_s || early_s);

  round_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr_i(timer_clr_s),
    .en_i (timer_en_s),
    .tc_o (tc_s)
  );

  always_comb begin
    state_d     = state_q;
    voted_d     = voted_q;
    vals_d      = vals_q;
    yes_cnt_d   = yes_cnt_q;
    result_d    = result_q;
    timed_out_d = timed_out_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (vrc.start) begin
          state_d   = COLLECT;
          voted_d   = '0;
          vals_d    = '0;
          yes_cnt_d = 2'd0;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        voted_d   = voted_new_s;
        vals_d    = vals_new_s;
        yes_cnt_d = popcnt3(vals_new_s);
        if (close_s) begin
          state_d     = IDLE;
          result_d    = maj3(vals_new_s);
          timed_out_d = ~(&voted_new_s) & ~early_s;
          done_d      = 1'b1;
        end else begin
          state_d = COLLECT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == COLLECT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      voted_q     <= '0;
      vals_q      <= '0;
      yes_cnt_q   <= 2'd0;
      result_q    <= 1'b0;
      timed_out_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      voted_q     <= voted_d;
      vals_q      <= vals_d;
      yes_cnt_q   <= yes_cnt_d;
      result_q    <= result_d;
      timed_out_q <= timed_out_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign vrc.busy      = busy_q;
  assign vrc.voted     = voted_q;
  assign vrc.yes_cnt   = yes_cnt_q;
  assign vrc.result    = result_q;
  assign vrc.timed_out = timed_out_q;
  assign vrc.done      = done_q;

endmodule

// File: tb/tb_vote_round_collector.sv
// Scoreboard bench for vote_round_collector with an 8-cycle voting window.
module tb_vote_round_collector;

  localparam int TO = 8;

  typedef struct {
    int         cyc;
    logic       result;
    logic       timed_out;
    logic [1:0] yes_cnt;
    logic [2:0] voted;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  vote_round_collector_if vrc ();

  vote_round_collector #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .rst(rst),
    .vrc(vrc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Pop the oldest expected round whenever the DUT reports a close.
  always @(negedge clk) begin
    if (vrc.done === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("done_cycle", cyc, e.cyc);
        check_val("result", {31'd0, vrc.result}, {31'd0, e.result});
        check_val("timed_out", {31'd0, vrc.timed_out}, {31'd0, e.timed_out});
        check_val("yes_cnt", {30'd0, vrc.yes_cnt}, {30'd0, e.yes_cnt});
        check_val("voted", {29'd0, vrc.voted}, {29'd0, e.voted});
        check_val("busy_at_done", {31'd0, vrc.busy}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic [2:0] vv, input logic [2:0] v);
    vrc.start      = s;
    vrc.vote_valid = vv;
    vrc.vote_val   = v;
  endtask

  task automatic push(input int c, input logic r, input logic t, input logic [1:0] y, input logic [2:0] vt);
    exp_t e;
    e.cyc = c; e.result = r; e.timed_out = t; e.yes_cnt = y; e.voted = vt;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || vrc.busy === 1'b1) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check_val("idle_wait_expired", 32'd0, 32'd1);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, {31'd0, vrc.busy}, 32'd0);
    check_val({tag, "_voted"}, {29'd0, vrc.voted}, 32'd0);
    check_val({tag, "_yes_cnt"}, {30'd0, vrc.yes_cnt}, 32'd0);
    check_val({tag, "_result"}, {31'd0, vrc.result}, 32'd0);
    check_val({tag, "_timed_out"}, {31'd0, vrc.timed_out}, 32'd0);
    check_val({tag, "_done"}, {31'd0, vrc.done}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    drive(1'b0, 3'b000, 3'b000);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_all_zero("reset");

    // Round 1: sequential votes 1,0,1 on judges 0,1,2.
    drive(1'b1, 3'b000, 3'b000); p = cyc + 1;
    push(p + 3, 1'b1, 1'b0, 2'd2, 3'b111);
    tick(); check_val("busy_after_start", {31'd0, vrc.busy}, 32'd1);
    drive(1'b0, 3'b001, 3'b001); tick();
    drive(1'b0, 3'b010, 3'b000); tick();
    drive(1'b0, 3'b100, 3'b100); tick();
    drive(1'b0, 3'b000, 3'b000);
    wait_idle();

    // Round 2: judge 1 votes yes then re-strobes no; round times out.
    drive(1'b1, 3'b000, 3'b000); p = cyc + 1;
    push(p + TO, 1'b0, 1'b1, 2'd1, 3'b010);
    tick();
    drive(1'b0, 3'b010, 3'b010); tick();
    check_val("mid_yes_cnt", {30'd0, vrc.yes_cnt}, 32'd1);
    check_val("mid_voted", {29'd0, vrc.voted}, 32'd2);
    drive(1'b0, 3'b010, 3'b000); tick();
    check_val("restrobe_yes_cnt", {30'd0, vrc.yes_cnt}, 32'd1);
    drive(1'b0, 3'b000, 3'b000);
    wait_idle();

    // Round 3: votes presented with start are ignored.
    drive(1'b1, 3'b111, 3'b111); p = cyc + 1;
    push(p + TO, 1'b0, 1'b1, 2'd0, 3'b000);
    tick();
    drive(1'b0, 3'b000, 3'b000); tick();
    check_val("start_votes_ignored", {29'd0, vrc.voted}, 32'd0);
    wait_idle();

    // Round 4: simultaneous votes, then back-to-back start in the done cycle.
    drive(1'b1, 3'b000, 3'b000); p = cyc + 1;
    push(p + 1, 1'b1, 1'b0, 2'd2, 3'b111);
    tick();
    drive(1'b0, 3'b111, 3'b110); tick();
    check_val("done_for_restart", {31'd0, vrc.done}, 32'd1);
    drive(1'b1, 3'b000, 3'b000); p = cyc + 1;
    push(p + 1, 1'b1, 1'b0, 2'd2, 3'b111);
    tick();
    check_val("busy_back_to_back", {31'd0, vrc.busy}, 32'd1);
    check_val("done_not_twice", {31'd0, vrc.done}, 32'd0);
    drive(1'b0, 3'b111, 3'b101); tick();
    drive(1'b0, 3'b000, 3'b000);
    wait_idle();

    // Round 5: reset mid-round discards it; next round runs normally.
    drive(1'b1, 3'b000, 3'b000); tick();
    drive(1'b0, 3'b001, 3'b001); tick();
    drive(1'b0, 3'b000, 3'b000); rst = 1'b1; tick();
    rst = 1'b0;
    check_all_zero("midround_rst");
    tick();
    check_val("no_done_after_rst", {31'd0, vrc.done}, 32'd0);
    drive(1'b1, 3'b000, 3'b000); p = cyc + 1;
    push(p + 1, 1'b1, 1'b0, 2'd3, 3'b111);
    tick();
    drive(1'b0, 3'b111, 3'b111); tick();
    drive(1'b0, 3'b000, 3'b000);
    wait_idle();

    // Round 6: judges 0 and 2 agree on yes; judge 1 never votes.
    drive(1'b1, 3'b000, 3'b000); p = cyc + 1;
`ifdef VOTE_EARLY_DECIDE_EN
    push(p + 2, 1'b1, 1'b0, 2'd2, 3'b101);
`else
    push(p + TO, 1'b1, 1'b1, 2'd2, 3'b101);
`endif
    tick();
    drive(1'b0, 3'b001, 3'b001); tick();
    drive(1'b0, 3'b100, 3'b100); tick();
    drive(1'b0, 3'b000, 3'b000);
    wait_idle();

    // Round 7: a vote landing in the final window cycle still counts.
    drive(1'b1, 3'b000, 3'b000); p = cyc + 1;
`ifdef VOTE_EARLY_DECIDE_EN
    push(p + TO, 1'b1, 1'b0, 2'd2, 3'b101);
`else
    push(p + TO, 1'b1, 1'b1, 2'd2, 3'b101);
`endif
    tick();
    drive(1'b0, 3'b001, 3'b001); tick();
    drive(1'b0, 3'b000, 3'b000);
    repeat (TO - 2) tick();
    drive(1'b0, 3'b100, 3'b100); tick();
    drive(1'b0, 3'b000, 3'b000);
    wait_idle();

    check_val("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
